// File: rtl/linear_network_pkg.sv
// Shared helpers for the linear multicast distribution network.
package linear_network_pkg;

  // Widest destination mask the helper supports (NUM_NODE must not exceed this).
  localparam int unsigned MAX_NODE = 64;

  typedef logic [MAX_NODE-1:0] mask_max_t;

  // Clears mask bits 0..k: the destinations already behind stage k.
  function automatic mask_max_t clear_low_bits(input mask_max_t mask, input int unsigned k);
    mask_max_t low;
    low = (mask_max_t'(1) << (k + 32'd1)) - mask_max_t'(1);
    return mask & ~low;
  endfunction

endpackage

// File: rtl/linear_network_mc_stage.sv
// One pipeline stage: holds a flit, delivers it to its own node and forwards
// the remaining destinations downstream, both under valid/ready handshakes.
module linear_network_mc_stage
  import linear_network_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODE   = 4,
  parameter int unsigned STAGE      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  // upstream link
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_NODE-1:0]   in_mask_i,
  // local node port
  output logic                  node_valid_o,
  input  logic                  node_ready_i,
  output logic [DATA_WIDTH-1:0] node_data_o,
  // downstream link
  output logic                  fwd_valid_o,
  input  logic                  fwd_ready_i,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic [NUM_NODE-1:0]   fwd_mask_o
);

  logic                  vld_q,  vld_d;
  logic                  dlv_q,  dlv_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_NODE-1:0]   mask_q, mask_d;

  logic [NUM_NODE-1:0]   fwd_mask;
  logic                  node_hs;
  logic                  deliv_done;
  logic                  fwd_need;
  logic                  fwd_done;
  logic                  retire;
  logic                  load;

  // Delivery/forward/retire decisions and next-state of the stage registers.
  always_comb begin
    fwd_mask     = NUM_NODE'(clear_low_bits(MAX_NODE'(mask_q), STAGE));
    node_valid_o = en_i && vld_q && mask_q[STAGE] && !dlv_q;
    node_hs      = node_valid_o && node_ready_i;
    deliv_done   = !mask_q[STAGE] || dlv_q || node_hs;
    fwd_need     = |fwd_mask;
    // The whole flit moves on only once the local delivery is settled.
    fwd_valid_o  = en_i && vld_q && fwd_need && deliv_done;
    fwd_done     = !fwd_need || (fwd_valid_o && fwd_ready_i);
    retire       = en_i && vld_q && deliv_done && fwd_done;
    in_ready_o   = en_i && (!vld_q || retire);
    load         = in_valid_i && in_ready_o;

    node_data_o  = node_valid_o ? data_q : '0;
    fwd_data_o   = data_q;
    fwd_mask_o   = fwd_mask;

    vld_d  = vld_q;
    dlv_d  = dlv_q;
    data_d = data_q;
    mask_d = mask_q;
    if (load) begin
      vld_d  = 1'b1;
      dlv_d  = 1'b0;
      data_d = in_data_i;
      mask_d = in_mask_i;
    end else if (retire) begin
      vld_d  = 1'b0;
      dlv_d  = 1'b0;
    end else if (node_hs) begin
      // Remember a delivery made while the forward is still blocked.
      dlv_d  = 1'b1;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dlv_q  <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      vld_q  <= vld_d;
      dlv_q  <= dlv_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/linear_network_multicast_pipe.sv
// Pipelined linear distribution network: one input stream carried along a
// chain of stages, each flit delivered to every node in its destination mask.
module linear_network_multicast_pipe
  import linear_network_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODE   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_valid,
  output logic                           i_ready,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [NUM_NODE-1:0]            i_cmd,
  output logic [NUM_NODE-1:0]            o_valid,
  input  logic [NUM_NODE-1:0]            o_ready,
  output logic [DATA_WIDTH*NUM_NODE-1:0] o_data_bus
);

  logic                  in_valid  [NUM_NODE];
  logic                  in_ready  [NUM_NODE];
  logic [DATA_WIDTH-1:0] in_data   [NUM_NODE];
  logic [NUM_NODE-1:0]   in_mask   [NUM_NODE];
  logic                  fwd_valid [NUM_NODE];
  logic                  fwd_ready [NUM_NODE];
  logic [DATA_WIDTH-1:0] fwd_data  [NUM_NODE];
  logic [NUM_NODE-1:0]   fwd_mask  [NUM_NODE];

  logic                  unused_tail;

  // Input acceptance; flits with an empty mask are accepted and dropped.
  assign i_ready = i_en && !rst && in_ready[0];

  // The last stage never forwards, so its downstream link is left open.
  assign unused_tail = ^{fwd_valid[NUM_NODE-1], fwd_data[NUM_NODE-1], fwd_mask[NUM_NODE-1]};

  for (genvar k = 0; k < NUM_NODE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign in_valid[k] = i_valid && (i_cmd != '0);
      assign in_data[k]  = i_data_bus;
      assign in_mask[k]  = i_cmd;
    end else begin : g_link
      assign in_valid[k] = fwd_valid[k-1];
      assign in_data[k]  = fwd_data[k-1];
      assign in_mask[k]  = fwd_mask[k-1];
    end

    if (k == NUM_NODE - 1) begin : g_tail
      assign fwd_ready[k] = 1'b0;
    end else begin : g_mid
      assign fwd_ready[k] = in_ready[k+1];
    end

    linear_network_mc_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_NODE   (NUM_NODE),
      .STAGE      (k)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .en_i         (i_en),
      .in_valid_i   (in_valid[k]),
      .in_ready_o   (in_ready[k]),
      .in_data_i    (in_data[k]),
      .in_mask_i    (in_mask[k]),
      .node_valid_o (o_valid[k]),
      .node_ready_i (o_ready[k]),
      .node_data_o  (o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .fwd_valid_o  (fwd_valid[k]),
      .fwd_ready_i  (fwd_ready[k]),
      .fwd_data_o   (fwd_data[k]),
      .fwd_mask_o   (fwd_mask[k])
    );
  end

endmodule

// File: tb/tb_linear_network_multicast_pipe.sv
// Self-checking bench: per-node expected-delivery queues fed from accepted
// input flits, directed latency vectors, corner sequences and random traffic.
module tb_linear_network_multicast_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned NN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_en;
  logic             i_valid;
  logic             i_ready;
  logic [DW-1:0]    i_data_bus;
  logic [NN-1:0]    i_cmd;
  logic [NN-1:0]    o_valid;
  logic [NN-1:0]    o_ready;
  logic [DW*NN-1:0] o_data_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt [NN];
  logic [DW-1:0] exp_q [NN][$];

  linear_network_multicast_pipe #(.DATA_WIDTH(DW), .NUM_NODE(NN)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data_bus (o_data_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int total_hs();
    int s = 0;
    for (int k = 0; k < NN; k++) s += hs_cnt[k];
    return s;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NN; k++) s += exp_q[k].size();
    return s;
  endfunction

  // Scoreboard: every accepted flit is owed once, in order, to each masked node.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NN; k++) exp_q[k].delete();
    end else begin
      if (!i_en) begin
        check("o_valid while disabled", 64'(o_valid), 64'd0);
        check("i_ready while disabled", 64'(i_ready), 64'd0);
      end
      for (int k = 0; k < NN; k++) begin
        logic [DW-1:0] sl;
        sl = o_data_bus[k*DW +: DW];
        if (o_valid[k]) begin
          if (o_ready[k]) begin
            hs_cnt[k]++;
            n_checks++;
            if (exp_q[k].size() == 0) begin
              n_fail++;
              $display("FAIL node%0d extra delivery: got 0x%0h expected none", k, sl);
            end else begin
              logic [DW-1:0] e;
              e = exp_q[k].pop_front();
              if (sl !== e) begin
                n_fail++;
                $display("FAIL node%0d data order: got 0x%0h expected 0x%0h", k, sl, e);
              end
            end
          end
        end else begin
          check($sformatf("node%0d idle slice zero", k), 64'(sl), 64'd0);
        end
      end
      if (i_valid && i_ready) begin
        for (int k = 0; k < NN; k++)
          if (i_cmd[k]) exp_q[k].push_back(i_data_bus);
      end
    end
  end

  // Offer one flit and hold it until accepted (called just after a rising edge).
  task automatic push(input logic [DW-1:0] d, input logic [NN-1:0] c);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    i_valid = 1'b1;
    i_data_bus = d;
    i_cmd = c;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL push timeout: i_ready low for %0d cycles, expected acceptance", n);
    end
  endtask

  // Let everything owed drain, then require every node queue to be empty.
  task automatic drain_check(input string tag);
    int n;
    n = 0;
    i_valid = 1'b0;
    i_en = 1'b1;
    o_ready = '1;
    while (pending() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NN; k++)
      check($sformatf("%s node%0d undelivered", tag, k), 64'(exp_q[k].size()), 64'd0);
  endtask

  typedef struct packed {
    logic [DW-1:0]      data;
    logic [NN-1:0]      cmd;
    logic [NN-1:0]      ready;
    logic [NN-1:0][3:0] lat;   // edges after driving until node visible, 0 = never
    logic [3:0]         hs;    // total handshakes expected
  } vec_t;

  vec_t vecs [6];
  int   hs0 [NN];
  int   first_e [NN];
  int   base;
  logic saw_block;
  logic stale;

  initial begin
    vecs[0] = '{32'hA5A5_A5A5, 4'b0100, 4'b1111, {4'd0, 4'd3, 4'd0, 4'd0}, 4'd1};
    vecs[1] = '{32'h1234_5678, 4'b1011, 4'b1111, {4'd4, 4'd0, 4'd2, 4'd1}, 4'd3};
    vecs[2] = '{32'hDEAD_BEEF, 4'b0001, 4'b1111, {4'd0, 4'd0, 4'd0, 4'd1}, 4'd1};
    vecs[3] = '{32'hCAFE_F00D, 4'b1000, 4'b1111, {4'd4, 4'd0, 4'd0, 4'd0}, 4'd1};
    vecs[4] = '{32'h0F0F_0F0F, 4'b1111, 4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, 4'd4};
    vecs[5] = '{32'h5555_5555, 4'b0000, 4'b1111, {4'd0, 4'd0, 4'd0, 4'd0}, 4'd0};

    for (int k = 0; k < NN; k++) hs_cnt[k] = 0;
    rst = 1'b1;
    i_en = 1'b1;
    i_valid = 1'b0;
    i_data_bus = '0;
    i_cmd = '0;
    o_ready = '1;
    #1;
    check("reset o_valid", 64'(o_valid), 64'd0);
    check("reset o_data_bus", 64'(o_data_bus[63:0]), 64'd0);
    check("reset i_ready", 64'(i_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: single flit into an idle pipe, first-visible edge per node.
    for (int v = 0; v < 6; v++) begin
      base = total_hs();
      o_ready = vecs[v].ready;
      i_valid = 1'b1;
      i_data_bus = vecs[v].data;
      i_cmd = vecs[v].cmd;
      #1;
      check($sformatf("vec%0d i_ready", v), 64'(i_ready), 64'd1);
      for (int k = 0; k < NN; k++) first_e[k] = 0;
      for (int e = 1; e <= 8; e++) begin
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        for (int k = 0; k < NN; k++)
          if (first_e[k] == 0 && o_valid[k]) first_e[k] = e;
      end
      for (int k = 0; k < NN; k++)
        check($sformatf("vec%0d node%0d latency", v, k), 64'(first_e[k]), 64'(vecs[v].lat[k]));
      check($sformatf("vec%0d handshakes", v), 64'(total_hs() - base), 64'(vecs[v].hs));
    end

    // Empty mask: accepted, nothing delivered.
    i_valid = 1'b1;
    i_cmd = '0;
    i_data_bus = 32'hFFFF_FFFF;
    #1;
    check("cmd0 i_ready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    stale = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (o_valid != '0) stale = 1'b1;
    end
    check("cmd0 no o_valid", 64'(stale), 64'd0);

    // Node 1 stalled while three broadcast flits enter.
    for (int k = 0; k < NN; k++) hs0[k] = hs_cnt[k];
    o_ready = 4'b1101;
    saw_block = 1'b0;
    fork
      begin
        push(32'hF000_0000, 4'b1111);
        push(32'hF000_0001, 4'b1111);
        push(32'hF000_0002, 4'b1111);
      end
      begin
        repeat (5) begin
          @(posedge clk);
          #3;
          if (!i_ready) saw_block = 1'b1;
        end
        o_ready = 4'b1111;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    check("stall back-pressure seen", 64'(saw_block), 64'd1);
    for (int k = 0; k < NN; k++)
      check($sformatf("stall node%0d count", k), 64'(hs_cnt[k] - hs0[k]), 64'd3);
    drain_check("stall");

    // Partial delivery held in stage 1 while stage 2 is blocked.
    for (int k = 0; k < NN; k++) hs0[k] = hs_cnt[k];
    o_ready = 4'b1011;
    push(32'hAAAA_0002, 4'b0100);
    push(32'hBBBB_0006, 4'b0110);
    for (int i = 0; i < 8; i++) begin
      o_ready[1] = ((i % 4) == 1 || (i % 4) == 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    check("partial node1 once", 64'(hs_cnt[1] - hs0[1]), 64'd1);
    check("partial node2 blocked", 64'(hs_cnt[2] - hs0[2]), 64'd0);
    o_ready = 4'b1111;
    repeat (8) @(posedge clk);
    #1;
    check("partial node2 after release", 64'(hs_cnt[2] - hs0[2]), 64'd2);
    check("partial node1 final", 64'(hs_cnt[1] - hs0[1]), 64'd1);
    drain_check("partial");

    // Enable dropped for three cycles mid-stream.
    for (int k = 0; k < NN; k++) hs0[k] = hs_cnt[k];
    fork
      begin
        for (int i = 0; i < 6; i++) push(32'hE000_0000 + DW'(i), 4'b1111);
      end
      begin
        repeat (3) @(posedge clk);
        #3;
        i_en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("en low o_valid", 64'(o_valid), 64'd0);
          check("en low i_ready", 64'(i_ready), 64'd0);
        end
        @(posedge clk);
        #3;
        i_en = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < NN; k++)
      check($sformatf("en node%0d count", k), 64'(hs_cnt[k] - hs0[k]), 64'd6);
    drain_check("enable");

    // Asynchronous reset while a flit is waiting at node 0.
    o_ready = 4'b1110;
    i_valid = 1'b1;
    i_data_bus = 32'h7777_7777;
    i_cmd = 4'b1111;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("pre-reset node0 valid", 64'(o_valid[0]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst o_valid", 64'(o_valid), 64'd0);
    check("async rst o_data_bus", 64'(o_data_bus[63:0]), 64'd0);
    check("async rst i_ready", 64'(i_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    o_ready = 4'b1111;
    i_valid = 1'b1;
    i_data_bus = 32'hBEEF_0003;
    i_cmd = 4'b1000;
    first_e[3] = 0;
    stale = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      if (o_valid[2:0] != '0) stale = 1'b1;
      if (first_e[3] == 0 && o_valid[3]) begin
        first_e[3] = e;
        check("post-reset node3 data", 64'(o_data_bus[3*DW +: DW]), 64'h0000_0000_BEEF_0003);
      end
    end
    check("post-reset node3 latency", 64'(first_e[3]), 64'd4);
    check("post-reset no stale flit", 64'(stale), 64'd0);
    drain_check("reset");

    // Random traffic, stalls and enable drops against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      i_en = ($urandom_range(0, 9) != 0);
      o_ready = NN'($urandom);
      i_valid = ($urandom_range(0, 2) != 0);
      i_data_bus = $urandom;
      i_cmd = ($urandom_range(0, 7) == 0) ? '0 : NN'($urandom);
      @(posedge clk);
      #1;
    end
    drain_check("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linear_network_multicast_pipe.md
Name: linear_network_multicast_pipe

Overview:
Pipelined linear distribution network. A single input stream is carried along a chain of NUM_NODE register stages, and each flit is delivered to every node whose bit is set in a per-flit destination mask, so both unicast and arbitrary multicast are supported. Stage k drives node k's output port. Every boundary (input, per-node outputs, stage-to-stage links) uses a valid/ready handshake, so any single stalled consumer back-pressures only the flits that still need to pass it. The block sits between a buffer or DMA front-end and a row of PEs.

Parameters:
DATA_WIDTH, 32, payload width in bits (any value >= 1)
NUM_NODE, 4, number of nodes and pipeline stages (>= 2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
i_en  input  1  global enable; low freezes the whole network
i_valid  input  1  input flit valid
i_ready  output  1  input flit accepted when i_valid && i_ready
i_data_bus  input  DATA_WIDTH  input payload
i_cmd  input  NUM_NODE  destination mask; bit k set delivers the flit to node k
o_valid  output  NUM_NODE  per-node output valid
o_ready  input  NUM_NODE  per-node consumer ready
o_data_bus  output  DATA_WIDTH*NUM_NODE  node k data on [k*DATA_WIDTH+:DATA_WIDTH]

Behaviour:
- Reset (asynchronous, active-high): all stage valid flags, masks, delivered flags and data registers clear to 0. o_valid=0, o_data_bus=0, i_ready=0 while rst is high.
- Stage k registers: vld, data, mask[NUM_NODE-1:0], dlv (delivered-to-node-k flag).
- Delivery: o_valid[k] = i_en && vld_k && mask_k[k] && !dlv_k. o_data_bus slice k = data_k when o_valid[k] is high, otherwise all zeros.
- Forwarding: fwd_mask_k = mask_k with bits 0..k cleared. Stage k requests a forward when vld_k && fwd_mask_k != 0. The forward completes when stage k+1 can accept.
- Delivery need is done when mask_k[k]=0, or dlv_k=1, or o_valid[k] && o_ready[k] this cycle.
- Forward need is done when fwd_mask_k==0, or the forward completes this cycle.
- Stage k retires when vld_k is set and both needs are done in the same cycle, or were satisfied earlier.
- A forward that completes while delivery is still pending is invalid. The forward is therefore gated until delivery is done. There is never partial forwarding; only delivery is tracked partially.
- dlv_k sets on a delivery handshake in a cycle where the stage does not retire, and clears when the stage retires or reloads.
- Stage k accepts new content when !vld_k or it retires this cycle. This allows full throughput of one flit per cycle with no bubbles.
- Stage 0 input: i_ready = i_en && stage-0-can-accept. A flit with i_cmd==0 is accepted and discarded; stage 0 is not loaded.
- Stage k+1 loads {data_k, fwd_mask_k} with dlv cleared.
- Latency with no stalls: a flit accepted at edge t is visible at node k after edge t+1+k, i.e. o_valid[k] is high in the cycle after edge t+1+k.
- i_en low: no state changes, i_ready=0, o_valid=0. Flits in flight hold and resume unchanged when i_en returns high.
- Ordering: flits reach each node in input order. There is no reordering and no duplication. Each set mask bit produces exactly one o_valid&&o_ready handshake at that node.
- Last stage: fwd_mask is always 0.
- o_ready is ignored for nodes with o_valid low.

Decomposition:
- Package linear_network_pkg: function clear_low_bits(mask, k) returning mask & ~((1<<(k+1))-1).
- Sub-module linear_network_mc_stage, one instance per node, generated. It contains the stage registers, the delivery/forward/retire logic and the dlv flag, with a NUM_NODE and stage-index parameter. The top level handles chaining, the i_cmd==0 drop, i_en gating and the output bus packing.

Test Plan:
- Unicast, NUM_NODE=4, all o_ready=1: flit 0xA5A5A5A5 with i_cmd=4'b0100 accepted at edge 0 -> o_valid=4'b0100 in the cycle after edge 3 with data 0xA5A5A5A5; all other output slices are zero.
- Multicast, i_cmd=4'b1011, all ready: node 0 sees the flit after edge 1, node 1 after edge 2, node 3 after edge 4; node 2 never asserts o_valid; exactly 3 handshakes in total.
- Stall: o_ready[1]=0 for 5 cycles, 3 back-to-back flits with mask 4'b1111 -> node 0 receives all 3; stages fill up and i_ready drops. Release -> node 1 then nodes 2 and 3 receive flits 0,1,2 in order, each exactly once.
- Partial delivery: o_ready[1] toggling 1,0,0,1 while stage 2 is stalled by o_ready[2]=0 -> node 1 handshakes once only (dlv prevents a re-send), and the flit later reaches node 2.
- i_cmd=0 with i_valid=1 -> i_ready=1, no o_valid anywhere. i_en low for 3 cycles mid-stream -> all o_valid=0 and i_ready=0, then the stream resumes with no loss.
- rst asserted asynchronously mid-flight, between clock edges -> o_valid=0 and o_data_bus=0 immediately. After release, a new unicast to node 3 arrives with the nominal 4-edge latency and no stale flit appears.
